// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: instruction word, predecoded opcode and the
// packed entry stored in the queue.
package fetch_queue_pkg;

  localparam int FQ_WORD_W = 32;

  typedef logic [FQ_WORD_W-1:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef struct packed {
    word_t   iload;
    word_t   laddr;
    opcode_t opcode;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Signal bundle for the fetch queue; fq is the queue's view, fqtb the
// fetch/decode (or bench) view.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int WORD_W = FQ_WORD_W,
  parameter int DEPTH  = 4
) (
  input logic CLK,
  input logic RST
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_iload;
  logic [WORD_W-1:0] in_laddr;
  opcode_t           in_opcode;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_iload;
  logic [WORD_W-1:0] out_laddr;
  opcode_t           out_opcode;
  logic [CNT_W-1:0]  count;

  modport fq (
    input  CLK, RST, flush, in_valid, in_iload, in_laddr, in_opcode, out_ready,
    output in_ready, out_valid, out_iload, out_laddr, out_opcode, count
  );

  modport fqtb (
    input  CLK, RST, in_ready, out_valid, out_iload, out_laddr, out_opcode, count,
    output flush, in_valid, in_iload, in_laddr, in_opcode, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Multi-entry FIFO instruction buffer between fetch and decode, with full flush
// and an optional zero-latency bypass when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = FQ_WORD_W,
  parameter bit BYPASS = 1'b0,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_iload,
  input  logic [WORD_W-1:0] in_laddr,
  input  opcode_t           in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_iload,
  output logic [WORD_W-1:0] out_laddr,
  output opcode_t           out_opcode,
  output logic [CNT_W-1:0]  count
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic      empty, full, bypass_hit, push, pop, pass_thru, do_write, do_read;
  fq_entry_t in_entry, head;

  assign in_entry = '{iload: word_t'(in_iload), laddr: word_t'(in_laddr), opcode: in_opcode};

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // in_ready depends only on state and reset, never on the handshakes
  assign in_ready   = !full && !RST;
  assign bypass_hit = BYPASS && empty && in_valid && !RST;
  assign out_valid  = (!empty || bypass_hit) && !RST;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign pass_thru = bypass_hit && out_ready;
  assign do_write  = push && !pass_thru && !flush;
  assign do_read   = pop && !pass_thru && !flush;

  always_comb begin
    head = '0;
    if (bypass_hit)
      head = in_entry;
    else if (!empty)
      head = mem[rd_ptr_reg];
  end

  assign out_iload  = WORD_W'(head.iload);
  assign out_laddr  = WORD_W'(head.laddr);
  assign out_opcode = head.opcode;
  assign count      = count_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_read)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_write, do_read})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is never cleared; count alone says which entries are live
  always_ff @(posedge CLK) begin
    if (do_write)
      mem[wr_ptr_reg] <= in_entry;
  end

  a_count_bound: assert property (@(posedge CLK) disable iff (RST) count_reg <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table on a BYPASS=0 instance plus
// hand-written bypass/latency sequences comparing BYPASS=0 and BYPASS=1.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_queue_if #(.WORD_W(32), .DEPTH(DEPTH)) fq_if (.CLK(CLK), .RST(RST));

  logic             b_in_ready, b_out_valid;
  logic [31:0]      b_out_iload, b_out_laddr;
  opcode_t          b_out_opcode;
  logic [CNT_W-1:0] b_count;

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(32), .BYPASS(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .flush(fq_if.flush),
    .in_valid(fq_if.in_valid), .in_ready(fq_if.in_ready),
    .in_iload(fq_if.in_iload), .in_laddr(fq_if.in_laddr), .in_opcode(fq_if.in_opcode),
    .out_valid(fq_if.out_valid), .out_ready(fq_if.out_ready),
    .out_iload(fq_if.out_iload), .out_laddr(fq_if.out_laddr), .out_opcode(fq_if.out_opcode),
    .count(fq_if.count)
  );

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(32), .BYPASS(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .flush(fq_if.flush),
    .in_valid(fq_if.in_valid), .in_ready(b_in_ready),
    .in_iload(fq_if.in_iload), .in_laddr(fq_if.in_laddr), .in_opcode(fq_if.in_opcode),
    .out_valid(b_out_valid), .out_ready(fq_if.out_ready),
    .out_iload(b_out_iload), .out_laddr(b_out_laddr), .out_opcode(b_out_opcode),
    .count(b_count)
  );

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] laddr;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_laddr;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic opcode_t op_of(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return OP_LW;
      2'd1:    return OP_BEQ;
      2'd2:    return OP_ADDI;
      default: return OP_SW;
    endcase
  endfunction

  function automatic void add(input logic rst, flush, iv, input logic [31:0] laddr,
                              input logic ordy, e_ir, e_ov, input logic [31:0] e_laddr,
                              input int e_cnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.laddr = laddr; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_laddr = e_laddr; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1 ns later
  task automatic drive(input logic rst, flush, iv, input logic [31:0] laddr, iload,
                       input logic ordy);
    @(negedge CLK);
    RST               = rst;
    fq_if.flush       = flush;
    fq_if.in_valid    = iv;
    fq_if.in_laddr    = laddr;
    fq_if.in_iload    = iload;
    fq_if.in_opcode   = op_of(laddr);
    fq_if.out_ready   = ordy;
    #1;
  endtask

  initial begin
    fq_if.flush = 1'b0; fq_if.in_valid = 1'b0; fq_if.in_iload = '0;
    fq_if.in_laddr = '0; fq_if.in_opcode = OP_RTYPE; fq_if.out_ready = 1'b0;

    // reset and release
    add(1,0,0,32'h0,0,   0,0,32'h0,0);
    add(0,0,0,32'h0,0,   1,0,32'h0,0);
    // fill to DEPTH, 5th push refused (also with simultaneous pop), then drain
    add(0,0,1,32'h0,0,   1,0,32'h0,0);
    add(0,0,1,32'h4,0,   1,1,32'h0,1);
    add(0,0,1,32'h8,0,   1,1,32'h0,2);
    add(0,0,1,32'hC,0,   1,1,32'h0,3);
    add(0,0,1,32'h10,0,  0,1,32'h0,4);
    add(0,0,1,32'h10,1,  0,1,32'h0,4);
    add(0,0,0,32'h0,1,   1,1,32'h4,3);
    add(0,0,0,32'h0,1,   1,1,32'h8,2);
    add(0,0,0,32'h0,1,   1,1,32'hC,1);
    add(0,0,0,32'h0,0,   1,0,32'h0,0);
    // wrap: hold count=3 across 10 push/pop pairs
    add(0,0,1,32'h100,0, 1,0,32'h0,0);
    add(0,0,1,32'h104,0, 1,1,32'h100,1);
    add(0,0,1,32'h108,0, 1,1,32'h100,2);
    for (int k = 0; k < 10; k++)
      add(0,0,1,32'h10C + 32'(4*k),1, 1,1,32'h100 + 32'(4*k),3);
    add(0,0,0,32'h0,1,   1,1,32'h128,3);
    // flush at count=2 with push and pop pending
    add(0,1,1,32'h200,1, 1,1,32'h12C,2);
    add(0,0,0,32'h0,0,   1,0,32'h0,0);
    add(0,0,0,32'h0,1,   1,0,32'h0,0);
    // reset mid-stream at count=3
    add(0,0,1,32'h300,0, 1,0,32'h0,0);
    add(0,0,1,32'h304,0, 1,1,32'h300,1);
    add(0,0,1,32'h308,0, 1,1,32'h300,2);
    add(0,0,0,32'h0,0,   1,1,32'h300,3);
    add(1,0,1,32'h30C,1, 0,0,32'h0,0);
    add(0,0,0,32'h0,0,   1,0,32'h0,0);
    // stall 3 cycles at count=1
    add(0,0,1,32'h400,0, 1,0,32'h0,0);
    add(0,0,0,32'h0,0,   1,1,32'h400,1);
    add(0,0,0,32'h0,0,   1,1,32'h400,1);
    add(0,0,0,32'h0,0,   1,1,32'h400,1);
    add(0,0,0,32'h0,1,   1,1,32'h400,1);
    add(0,0,0,32'h0,0,   1,0,32'h0,0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.flush, v.iv, v.laddr, ~v.laddr, v.ordy);
      $display("vec %0d: rst=%0b flush=%0b iv=%0b laddr=%h ordy=%0b -> ir=%0b ov=%0b laddr=%h cnt=%0d",
               i, v.rst, v.flush, v.iv, v.laddr, v.ordy,
               fq_if.in_ready, fq_if.out_valid, fq_if.out_laddr, fq_if.count);
      chk($sformatf("vec%0d in_ready", i),  32'(fq_if.in_ready),  32'(v.e_ir));
      chk($sformatf("vec%0d out_valid", i), 32'(fq_if.out_valid), 32'(v.e_ov));
      chk($sformatf("vec%0d out_laddr", i), fq_if.out_laddr,      v.e_laddr);
      chk($sformatf("vec%0d out_iload", i), fq_if.out_iload,      v.e_ov ? ~v.e_laddr : 32'h0);
      chk($sformatf("vec%0d out_opcode", i), 32'(fq_if.out_opcode),
          v.e_ov ? 32'(op_of(v.e_laddr)) : 32'(OP_RTYPE));
      chk($sformatf("vec%0d count", i),     32'(fq_if.count),     32'(v.e_cnt));
    end

    // bypass vs. registered latency
    drive(1,0,1,32'h500,32'hDEADBEEF,1);
    $display("seq bypass: reset with in_valid=1, bypass ov=%0b", b_out_valid);
    chk("byp rst out_valid", 32'(b_out_valid), 32'h0);
    chk("byp rst in_ready",  32'(b_in_ready),  32'h0);
    drive(0,0,0,32'h0,32'h0,0);
    drive(0,0,1,32'h500,32'hDEADBEEF,1);
    $display("seq bypass: push DEADBEEF empty, byp iload=%h q iload=%h", b_out_iload, fq_if.out_iload);
    chk("byp same-cycle out_valid", 32'(b_out_valid), 32'h1);
    chk("byp same-cycle out_iload", b_out_iload,      32'hDEADBEEF);
    chk("byp same-cycle out_laddr", b_out_laddr,      32'h500);
    chk("byp same-cycle count",     32'(b_count),     32'h0);
    chk("nobyp same-cycle out_valid", 32'(fq_if.out_valid), 32'h0);
    chk("nobyp same-cycle out_iload", fq_if.out_iload,      32'h0);
    drive(0,0,0,32'h0,32'h0,1);
    $display("seq bypass: next cycle, byp cnt=%0d q iload=%h", b_count, fq_if.out_iload);
    chk("byp next count",          32'(b_count),          32'h0);
    chk("byp next out_valid",      32'(b_out_valid),      32'h0);
    chk("nobyp next out_valid",    32'(fq_if.out_valid),  32'h1);
    chk("nobyp next out_iload",    fq_if.out_iload,       32'hDEADBEEF);
    drive(0,0,0,32'h0,32'h0,0);
    chk("nobyp drained count",     32'(fq_if.count),      32'h0);

    // bypass view without a pop still stores the entry
    drive(0,0,1,32'h600,32'h12345678,0);
    $display("seq bypass-store: byp ov=%0b iload=%h cnt=%0d", b_out_valid, b_out_iload, b_count);
    chk("bypst view out_iload", b_out_iload,  32'h12345678);
    chk("bypst view count",     32'(b_count), 32'h0);
    drive(0,0,1,32'h604,32'hCAFEF00D,1);
    $display("seq bypass-store: byp iload=%h cnt=%0d", b_out_iload, b_count);
    chk("bypst head out_iload", b_out_iload,  32'h12345678);
    chk("bypst head count",     32'(b_count), 32'h1);
    drive(0,0,0,32'h0,32'h0,0);
    $display("seq bypass-store: byp iload=%h cnt=%0d", b_out_iload, b_count);
    chk("bypst next out_iload", b_out_iload,  32'hCAFEF00D);
    chk("bypst next count",     32'(b_count), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
